// File: rtl/alu_rs.sv
// Integer ALU reservation station: captures dispatched micro-ops, wakes pending
// operands from the CDB and issues the oldest ready entry into a registered ALU port.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif
`ifndef ADD
`define ADD  4'd1
`define SUB  4'd2
`define AND  4'd3
`define OR   4'd4
`define XOR  4'd5
`define SLL  4'd6
`define SRL  4'd7
`define SRA  4'd8
`define SLT  4'd9
`define SLTU 4'd10
`define OUTA 4'd11
`define OUTB 4'd12
`endif

module alu_rs_entry #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr,
  input  logic             clr,
  input  logic [3:0]       d_op,
  input  logic [31:0]      d_vj,
  input  logic [31:0]      d_vk,
  input  logic             d_qj_pend,
  input  logic             d_qk_pend,
  input  logic [TAG_W-1:0] d_qj,
  input  logic [TAG_W-1:0] d_qk,
  input  logic [TAG_W-1:0] d_dest,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             busy,
  output logic             ready,
  output logic [3:0]       op,
  output logic [31:0]      vj,
  output logic [31:0]      vk,
  output logic [TAG_W-1:0] dest
);
  logic             qj_pend, qk_pend;
  logic [TAG_W-1:0] qj, qk;
  logic             dj_hit, dk_hit, j_hit, k_hit;

  // Bypass at dispatch and wakeup of resident entries use the same broadcast.
  assign dj_hit = d_qj_pend & cdb_valid & (cdb_tag == d_qj);
  assign dk_hit = d_qk_pend & cdb_valid & (cdb_tag == d_qk);
  assign j_hit  = busy & qj_pend & cdb_valid & (cdb_tag == qj);
  assign k_hit  = busy & qk_pend & cdb_valid & (cdb_tag == qk);
  assign ready  = busy & ~qj_pend & ~qk_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; op <= '0; vj <= '0; vk <= '0; dest <= '0;
      qj_pend <= 1'b0; qk_pend <= 1'b0; qj <= '0; qk <= '0;
    end else if (flush) begin
      busy <= 1'b0; qj_pend <= 1'b0; qk_pend <= 1'b0;
    end else if (wr) begin
      busy    <= 1'b1;
      op      <= d_op;
      dest    <= d_dest;
      qj      <= d_qj;
      qk      <= d_qk;
      qj_pend <= d_qj_pend & ~dj_hit;
      qk_pend <= d_qk_pend & ~dk_hit;
      vj      <= dj_hit ? cdb_data : d_vj;
      vk      <= dk_hit ? cdb_data : d_vk;
    end else begin
      if (clr) busy <= 1'b0;
      if (j_hit) begin vj <= cdb_data; qj_pend <= 1'b0; end
      if (k_hit) begin vk <= cdb_data; qk_pend <= 1'b0; end
    end
  end
endmodule

module alu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = `ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [3:0]                 disp_op,
  input  logic [31:0]                disp_vj,
  input  logic [31:0]                disp_vk,
  input  logic                       disp_qj_pend,
  input  logic                       disp_qk_pend,
  input  logic [TAG_W-1:0]           disp_qj,
  input  logic [TAG_W-1:0]           disp_qk,
  input  logic [TAG_W-1:0]           disp_dest,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_data,
  input  logic                       issue_stall,
  output logic [3:0]                 alu_op,
  output logic [31:0]                alu_src_a,
  output logic [31:0]                alu_src_b,
  output logic [TAG_W-1:0]           alu_dest,
  output logic [$clog2(DEPTH+1)-1:0] rs_count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]             busy, ready, alloc, sel, wr, clr;
  logic [DEPTH-1:0][3:0]        e_op;
  logic [DEPTH-1:0][31:0]       e_vj, e_vk;
  logic [DEPTH-1:0][TAG_W-1:0]  e_dest;
  // older[i][j] = entry i was dispatched before entry j
  logic [DEPTH-1:0][DEPTH-1:0]  older;
  logic                         taken, disp_fire, issue;
  logic [3:0]                   sel_op;
  logic [31:0]                  sel_vj, sel_vk;
  logic [TAG_W-1:0]             sel_dest;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    alu_rs_entry #(.TAG_W(TAG_W)) u_ent (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr[g]), .clr(clr[g]),
      .d_op(disp_op), .d_vj(disp_vj), .d_vk(disp_vk),
      .d_qj_pend(disp_qj_pend), .d_qk_pend(disp_qk_pend),
      .d_qj(disp_qj), .d_qk(disp_qk), .d_dest(disp_dest),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .busy(busy[g]), .ready(ready[g]), .op(e_op[g]),
      .vj(e_vj[g]), .vk(e_vk[g]), .dest(e_dest[g])
    );
  end

  assign disp_ready = ~&busy;
  assign disp_fire  = disp_valid & disp_ready;
  assign wr         = alloc & {DEPTH{disp_fire}};
  assign issue      = (|ready) & ~issue_stall;
  assign clr        = sel & {DEPTH{issue}};

  always_comb begin
    alloc = '0;
    taken = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !taken) begin
        alloc[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

  always_comb begin
    sel      = ready;
    sel_op   = '0;
    sel_vj   = '0;
    sel_vk   = '0;
    sel_dest = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older[j][i]) sel[i] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        sel_op   = sel_op   | e_op[i];
        sel_vj   = sel_vj   | e_vj[i];
        sel_vk   = sel_vk   | e_vk[i];
        sel_dest = sel_dest | e_dest[i];
      end
    end
  end

  // New entry is younger than every entry still resident.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older <= '0;
    end else if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (alloc[j])      older[i][j] <= busy[i];
          else if (alloc[i]) older[i][j] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= '0; alu_src_a <= '0; alu_src_b <= '0; alu_dest <= '0;
    end else if (flush) begin
      alu_op <= '0;
    end else if (!issue_stall) begin
      if (|ready) begin
        alu_op    <= sel_op;
        alu_src_a <= sel_vj;
        alu_src_b <= sel_vk;
        alu_dest  <= sel_dest;
      end else begin
        alu_op <= '0;
      end
    end
  end

  always_comb begin
    rs_count = '0;
    for (int i = 0; i < DEPTH; i++) rs_count = rs_count + CW'(busy[i]);
  end
endmodule
